fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_stream_pkg.sv | 9 +
 rtl/fifo_rd_skid.sv | 50 +++++
 rtl/fifo_rd_stream.sv | 57 +++++
 tb/tb_fifo_rd_stream.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_stream_pkg.sv
// fifo_rd_stream shared types and constants.
// Output buffer depth and occupancy type.
package fifo_rd_stream_pkg;

  localparam int BUF_DEPTH = 2;

  typedef logic [1:0] lvl_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry ordered output buffer.
// Captures one word per cycle behind any word still held after a pop.
module fifo_rd_skid
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH_FIFO = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [WIDTH_FIFO-1:0] push_data,
  input  logic                  pop,
  output logic [WIDTH_FIFO-1:0] head,
  output lvl_t                  level
);

  logic [WIDTH_FIFO-1:0] buf0_q, buf0_d;
  logic [WIDTH_FIFO-1:0] buf1_q, buf1_d;
  lvl_t                  cnt_q, cnt_d;
  lvl_t                  cnt_after;

  always_comb begin
    cnt_after = cnt_q - lvl_t'(pop);
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    if (pop) buf0_d = buf1_q;
    // new word lands at the head only if nothing remains after the pop
    if (push) begin
      if (cnt_after == '0) buf0_d = push_data;
      else                 buf1_d = push_data;
    end
    cnt_d = cnt_after + lvl_t'(push);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_q <= '0;
      buf1_q <= '0;
      cnt_q  <= '0;
    end else begin
      buf0_q <= buf0_d;
      buf1_q <= buf1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head  = buf0_q;
  assign level = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO pop port to valid/ready stream adapter.
// Issues pops so buffered plus in-flight words never exceed two.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int WIDTH_FIFO = 8,
  parameter int DLY        = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [WIDTH_FIFO-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH_FIFO-1:0] out_data,
  output logic [1:0]            out_level,
  output logic                  busy
);

  logic       inflight_q, inflight_d;
  logic       pop;
  lvl_t       level;
  logic [2:0] pending;

  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign pending   = 3'(level) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    fifo_ren   = drain_en & ~fifo_empty
               & (pending < 3'(BUF_DEPTH));
    inflight_d = fifo_ren;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_q <= 1'b0;
    else        inflight_q <= inflight_d;
  end

  fifo_rd_skid #(
    .WIDTH_FIFO(WIDTH_FIFO)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight_q),
    .push_data(fifo_rdata),
    .pop      (pop),
    .head     (out_data),
    .level    (level)
  );

  assign out_level = level;
  assign busy      = inflight_q | out_valid;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream with a queue-based FIFO model.
// Scoreboard tracks popped words until delivery.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       drain_en;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_ren;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] out_level;
  logic       busy;

  always #5 clk = ~clk;

  fifo_rd_stream #(
    .WIDTH_FIFO(8),
    .DLY       (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_ren  (fifo_ren),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_level (out_level),
    .busy      (busy)
  );

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  logic       last_ren;
  logic       hold_prev;
  logic [7:0] prev_data;
  int         n_chk;
  int         n_fail;
  int         n_ren;
  int         n_del;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    last_ren   = 1'b0;
    hold_prev  = 1'b0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
  endtask

  task automatic cyc();
    int   lvl;
    logic e_pop;
    logic e_ren;
    #1;
    lvl   = exp_q.size() - (last_ren ? 1 : 0);
    e_pop = out_ready && (lvl > 0);
    e_ren = drain_en && (fq.size() > 0)
         && ((exp_q.size() - int'(e_pop)) < 2);
    check("lvl_max", 32'(out_level <= 2), 1);
    check("level", 32'(out_level), lvl);
    check("valid", 32'(out_valid), 32'(lvl > 0));
    check("busy", 32'(busy), 32'(exp_q.size() > 0));
    check("ren", 32'(fifo_ren), 32'(e_ren));
    if (lvl > 0) check("data", 32'(out_data), 32'(exp_q[0]));
    if (hold_prev) check("stable", 32'(out_data), 32'(prev_data));
    hold_prev = out_valid && !out_ready;
    prev_data = out_data;
    n_ren += int'(e_ren);
    n_del += int'(e_pop);
    @(posedge clk);
    @(negedge clk);
    if (e_pop) void'(exp_q.pop_front());
    if (e_ren) begin
      fifo_rdata = fq.pop_front();
      exp_q.push_back(fifo_rdata);
    end
    last_ren   = e_ren;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic flush();
    int k;
    drain_en  = 1'b1;
    out_ready = 1'b1;
    k = 0;
    while ((fq.size() > 0 || exp_q.size() > 0) && k < 60) begin
      cyc();
      k++;
    end
    check("flush_done", 32'(fq.size() + exp_q.size()), 0);
    cyc();
  endtask

  initial begin
    int r0;
    int d0;
    int k;
    n_chk = 0; n_fail = 0; n_ren = 0; n_del = 0;
    prev_data = '0;
    rst_n = 1'b0; drain_en = 1'b0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_level", 32'(out_level), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ren", 32'(fifo_ren), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // three words, free-flowing output
    drain_en = 1'b1; out_ready = 1'b1;
    d0 = n_del;
    wr(8'h11); wr(8'h22); wr(8'h33);
    for (int i = 0; i < 5; i++) cyc();
    check("t1_delivered", 32'(n_del - d0), 3);
    #1;
    check("t1_busy_low", 32'(busy), 0);
    @(negedge clk);

    // backpressure with a full FIFO
    out_ready = 1'b0;
    r0 = n_ren;
    for (int i = 0; i < 8; i++) wr(8'(i));
    for (int i = 0; i < 6; i++) cyc();
    check("t2_pops", 32'(n_ren - r0), 2);
    #1;
    check("t2_level", 32'(out_level), 2);
    check("t2_data", 32'(out_data), 0);
    @(negedge clk);
    out_ready = 1'b1;
    d0 = n_del;
    for (int i = 0; i < 8; i++) cyc();
    check("t2_burst", 32'(n_del - d0), 8);
    flush();

    // random ready / drain against 64 words
    d0 = n_del;
    k  = 0;
    for (int w = 0; w < 64 || fq.size() > 0; ) begin
      if (w < 64 && fq.size() < 8 && $urandom_range(0, 3) != 0) begin
        wr(8'($urandom));
        w++;
      end
      out_ready = 1'($urandom_range(0, 1));
      drain_en  = ($urandom_range(0, 7) != 0);
      cyc();
      k++;
      if (k > 3000) break;
    end
    flush();
    check("t3_words", 32'(n_del - d0), 64);

    // drain_en drop right after an accepted pop
    out_ready = 1'b0;
    drain_en  = 1'b1;
    wr(8'hA5); wr(8'h5A);
    r0 = n_ren;
    cyc();
    drain_en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    check("t4_pops", 32'(n_ren - r0), 1);
    #1;
    check("t4_level", 32'(out_level), 1);
    check("t4_data", 32'(out_data), 32'h A5);
    @(negedge clk);
    flush();

    // asynchronous reset with a full buffer
    out_ready = 1'b0;
    drain_en  = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 32'(out_valid), 0);
    check("t5_data", 32'(out_data), 0);
    check("t5_level", 32'(out_level), 0);
    check("t5_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    #1;
    check("t5_ren", 32'(fifo_ren), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
